// File: rtl/pifo_lane_sequencer.sv
// pifo_lane_sequencer
// Initiator-side sequencer for one PIFO lane. Commands (push/pop) enter a
// small FIFO, an issue FSM turns the head command into a one-cycle strobe
// when the lane can take it, and pop results are captured a fixed POP_LAT
// cycles later into a first-word fall-through response FIFO.
// Pops are only issued when the response FIFO is sure to have room for the
// result (credits = RSP_DEPTH - rsp_count - inflight_pops), so capture never
// has to stall.
// Optional build macro: PIFO_LANE_SEQ_STATS_EN adds saturating push, pop and
// stall counters on extra output ports.

module pifo_lane_sequencer #(
  parameter int PTW           = 16,
  parameter int TREE_NUM      = 8,
  parameter int TREE_NUM_BITS = $clog2(TREE_NUM),
  parameter int POP_LAT       = 2,
  parameter int CMD_DEPTH     = 4,
  parameter int RSP_DEPTH     = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_cmd_valid,
  output logic                     o_cmd_ready,
  input  logic                     i_cmd_op,
  input  logic [TREE_NUM_BITS-1:0] i_cmd_tree_id,
  input  logic [PTW-1:0]           i_cmd_data,
  output logic                     o_push,
  output logic                     o_pop,
  output logic [PTW-1:0]           o_push_data,
  output logic [TREE_NUM_BITS-1:0] o_tree_id,
  input  logic                     i_task_fifo_full,
  input  logic [PTW-1:0]           i_pop_data,
  output logic                     o_rsp_valid,
  input  logic                     i_rsp_ready,
  output logic [PTW-1:0]           o_rsp_data,
  output logic [TREE_NUM_BITS-1:0] o_rsp_tree_id,
  output logic                     o_busy
`ifdef PIFO_LANE_SEQ_STATS_EN
  ,
  output logic [31:0]              o_stat_push_cnt,
  output logic [31:0]              o_stat_pop_cnt,
  output logic [31:0]              o_stat_stall_cnt
`endif
);

  localparam int CPW = $clog2(CMD_DEPTH);
  localparam int CCW = CPW + 1;
  localparam int RPW = $clog2(RSP_DEPTH);
  localparam int RCW = RPW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    STALL = 2'd2
  } state_t;

  state_t state_reg;

  // ---------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------
  logic                     cmd_op_mem   [CMD_DEPTH];
  logic [TREE_NUM_BITS-1:0] cmd_tree_mem [CMD_DEPTH];
  logic [PTW-1:0]           cmd_data_mem [CMD_DEPTH];
  logic [CPW-1:0]           cmd_wr_ptr_reg;
  logic [CPW-1:0]           cmd_rd_ptr_reg;
  logic [CCW-1:0]           cmd_count_reg;

  logic                     cmd_wr;
  logic                     cmd_rd;
  logic                     cmd_nonempty;
  logic                     head_op;
  logic [TREE_NUM_BITS-1:0] head_tree;
  logic [PTW-1:0]           head_data;

  // Ready comes straight from the registered occupancy, never from i_cmd_valid.
  assign o_cmd_ready  = (cmd_count_reg != CCW'(CMD_DEPTH));
  assign cmd_wr       = i_cmd_valid & o_cmd_ready;
  assign cmd_nonempty = (cmd_count_reg != '0);
  assign head_op      = cmd_op_mem[cmd_rd_ptr_reg];
  assign head_tree    = cmd_tree_mem[cmd_rd_ptr_reg];
  assign head_data    = cmd_data_mem[cmd_rd_ptr_reg];

  // Command storage; no reset so the arrays stay plain memories.
  always_ff @(posedge i_clk) begin
    if (cmd_wr) begin
      cmd_op_mem[cmd_wr_ptr_reg]   <= i_cmd_op;
      cmd_tree_mem[cmd_wr_ptr_reg] <= i_cmd_tree_id;
      cmd_data_mem[cmd_wr_ptr_reg] <= i_cmd_data;
    end
  end

  // Command FIFO pointers and occupancy.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cmd_wr_ptr_reg <= '0;
      cmd_rd_ptr_reg <= '0;
      cmd_count_reg  <= '0;
    end else begin
      if (cmd_wr) cmd_wr_ptr_reg <= cmd_wr_ptr_reg + CPW'(1);
      if (cmd_rd) cmd_rd_ptr_reg <= cmd_rd_ptr_reg + CPW'(1);
      case ({cmd_wr, cmd_rd})
        2'b10:   cmd_count_reg <= cmd_count_reg + CCW'(1);
        2'b01:   cmd_count_reg <= cmd_count_reg - CCW'(1);
        default: cmd_count_reg <= cmd_count_reg;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Credit accounting
  // ---------------------------------------------------------------------
  logic [RCW-1:0] inflight_reg;
  logic [RCW-1:0] rsp_count_reg;
  logic [RCW:0]   credit_used;
  logic           pop_ok;
  logic           head_eligible;
  logic           issue_fire;
  logic           pop_fire;
  logic           cap_valid;

  assign credit_used   = {1'b0, rsp_count_reg} + {1'b0, inflight_reg};
  assign pop_ok        = (credit_used < (RCW+1)'(RSP_DEPTH));
  assign head_eligible = head_op ? pop_ok : !i_task_fifo_full;
  assign issue_fire    = ((state_reg == ISSUE) || (state_reg == STALL)) &&
                         cmd_nonempty && head_eligible;
  assign pop_fire      = issue_fire & head_op;
  assign cmd_rd        = issue_fire;

  // Pops issued but not yet captured; up on issue, down on capture.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      inflight_reg <= '0;
    end else begin
      case ({pop_fire, cap_valid})
        2'b10:   inflight_reg <= inflight_reg + RCW'(1);
        2'b01:   inflight_reg <= inflight_reg - RCW'(1);
        default: inflight_reg <= inflight_reg;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Issue FSM with registered strobes
  // ---------------------------------------------------------------------
  // STALL issues directly on the first eligible cycle so a push goes out as
  // soon as the lane backpressure drops.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg   <= IDLE;
      o_push      <= 1'b0;
      o_pop       <= 1'b0;
      o_push_data <= '0;
      o_tree_id   <= '0;
    end else begin
      o_push      <= 1'b0;
      o_pop       <= 1'b0;
      o_push_data <= '0;
      case (state_reg)
        IDLE: begin
          if (cmd_nonempty) state_reg <= ISSUE;
        end
        ISSUE, STALL: begin
          if (issue_fire) begin
            o_push      <= !head_op;
            o_pop       <= head_op;
            o_push_data <= head_op ? '0 : head_data;
            o_tree_id   <= head_tree;
            if ((cmd_count_reg > CCW'(1)) || cmd_wr) state_reg <= ISSUE;
            else                                     state_reg <= IDLE;
          end else begin
            state_reg <= STALL;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Pop pipeline: tracks which cycle the lane's pop data becomes valid
  // ---------------------------------------------------------------------
  for (genvar gi = 0; gi < POP_LAT; gi++) begin : g_stage
    logic                     stage_valid;
    logic [TREE_NUM_BITS-1:0] stage_tree;
    logic                     in_valid;
    logic [TREE_NUM_BITS-1:0] in_tree;

    if (gi == 0) begin : g_head
      assign in_valid = o_pop;
      assign in_tree  = o_tree_id;
    end else begin : g_tail
      assign in_valid = g_stage[gi-1].stage_valid;
      assign in_tree  = g_stage[gi-1].stage_tree;
    end

    // One pipeline stage; valid is cleared by reset so late data is dropped.
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        stage_valid <= 1'b0;
        stage_tree  <= '0;
      end else begin
        stage_valid <= in_valid;
        stage_tree  <= in_tree;
      end
    end
  end

  logic [TREE_NUM_BITS-1:0] cap_tree;
  assign cap_valid = g_stage[POP_LAT-1].stage_valid;
  assign cap_tree  = g_stage[POP_LAT-1].stage_tree;

  // ---------------------------------------------------------------------
  // Response FIFO (first-word fall-through)
  // ---------------------------------------------------------------------
  logic [PTW-1:0]           rsp_data_mem [RSP_DEPTH];
  logic [TREE_NUM_BITS-1:0] rsp_tree_mem [RSP_DEPTH];
  logic [RPW-1:0]           rsp_wr_ptr_reg;
  logic [RPW-1:0]           rsp_rd_ptr_reg;
  logic                     rsp_rd;

  assign o_rsp_valid   = (rsp_count_reg != '0);
  assign rsp_rd        = o_rsp_valid & i_rsp_ready;
  assign o_rsp_data    = rsp_data_mem[rsp_rd_ptr_reg];
  assign o_rsp_tree_id = rsp_tree_mem[rsp_rd_ptr_reg];

  // Response storage; the credit rule guarantees a free slot on capture.
  always_ff @(posedge i_clk) begin
    if (cap_valid) begin
      rsp_data_mem[rsp_wr_ptr_reg] <= i_pop_data;
      rsp_tree_mem[rsp_wr_ptr_reg] <= cap_tree;
    end
  end

  // Response FIFO pointers and occupancy.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rsp_wr_ptr_reg <= '0;
      rsp_rd_ptr_reg <= '0;
      rsp_count_reg  <= '0;
    end else begin
      if (cap_valid) rsp_wr_ptr_reg <= rsp_wr_ptr_reg + RPW'(1);
      if (rsp_rd)    rsp_rd_ptr_reg <= rsp_rd_ptr_reg + RPW'(1);
      case ({cap_valid, rsp_rd})
        2'b10:   rsp_count_reg <= rsp_count_reg + RCW'(1);
        2'b01:   rsp_count_reg <= rsp_count_reg - RCW'(1);
        default: rsp_count_reg <= rsp_count_reg;
      endcase
    end
  end

  assign o_busy = cmd_nonempty || (inflight_reg != '0) || (rsp_count_reg != '0);

`ifdef PIFO_LANE_SEQ_STATS_EN
  // Saturating activity counters.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_stat_push_cnt  <= '0;
      o_stat_pop_cnt   <= '0;
      o_stat_stall_cnt <= '0;
    end else begin
      if (o_push && (o_stat_push_cnt != '1))
        o_stat_push_cnt <= o_stat_push_cnt + 32'd1;
      if (o_pop && (o_stat_pop_cnt != '1))
        o_stat_pop_cnt <= o_stat_pop_cnt + 32'd1;
      if ((state_reg == STALL) && (o_stat_stall_cnt != '1))
        o_stat_stall_cnt <= o_stat_stall_cnt + 32'd1;
    end
  end
`else
`endif

endmodule

// File: doc/pifo_lane_sequencer.md
Name: pifo_lane_sequencer

Overview:
- Initiator-side sequencer for one lane of the PIFO_SRAM_TOP push/pop interface.
- Accepts push/pop commands over valid/ready and drives the lane's push/pop strobes, respecting i_task_fifo_full.
- Captures the pop result a fixed POP_LAT cycles after each pop and returns it through a response valid/ready buffer.
- One instance per LEVEL lane; the instances sit between the scheduler logic and the PIFO top.

Parameters:
- PTW, 16: priority/data width.
- TREE_NUM, 8: number of logical trees.
- TREE_NUM_BITS, $clog2(TREE_NUM): tree id width.
- POP_LAT, 2: cycles from o_pop high to i_pop_data valid; must be >= 1.
- CMD_DEPTH, 4: command FIFO entries; power of 2, >= 2.
- RSP_DEPTH, 4: response FIFO entries; power of 2, >= 2.

Ports:
- i_clk  in  1  clock; single clock domain.
- i_rst  in  1  synchronous active-high reset.
- i_cmd_valid  in  1  command offered.
- o_cmd_ready  out  1  command FIFO not full.
- i_cmd_op  in  1  0 = push, 1 = pop.
- i_cmd_tree_id  in  TREE_NUM_BITS  target tree.
- i_cmd_data  in  PTW  push data; ignored for pop.
- o_push  out  1  push strobe to PIFO lane.
- o_pop  out  1  pop strobe to PIFO lane.
- o_push_data  out  PTW  push data; 0 when o_push is low.
- o_tree_id  out  TREE_NUM_BITS  tree id for the strobe; holds last value when idle.
- i_task_fifo_full  in  1  lane backpressure from PIFO.
- i_pop_data  in  PTW  pop result, valid POP_LAT cycles after o_pop.
- o_rsp_valid  out  1  response available.
- i_rsp_ready  in  1  consumer accepts response.
- o_rsp_data  out  PTW  popped value.
- o_rsp_tree_id  out  TREE_NUM_BITS  tree the value came from.
- o_busy  out  1  any command queued, pop in flight, or response pending.

Behaviour:
- Reset (i_rst high at a posedge): all FIFOs emptied, pipeline cleared.
  - Outputs after reset: o_push=0, o_pop=0, o_push_data=0, o_tree_id=0, o_rsp_valid=0, o_busy=0, o_cmd_ready=1.
  - In-flight pops are discarded. A pop_data arriving after reset is ignored.
- Command FIFO:
  - Write when i_cmd_valid & o_cmd_ready.
  - o_cmd_ready = !cmd_full, registered occupancy, no combinational path from i_cmd_valid.
- Issue FSM states: IDLE, ISSUE, STALL.
  - IDLE: command FIFO empty -> no strobes. Go to ISSUE the cycle after the FIFO becomes non-empty.
  - ISSUE: the head command is eligible when:
    - push: !i_task_fifo_full.
    - pop: credits > 0, where credits = RSP_DEPTH - rsp_count - inflight_pops.
  - If eligible: register the strobe plus tree_id/data and dequeue the head. Stay in ISSUE if more commands remain, else go to IDLE.
  - If not eligible: go to STALL, with no strobe.
  - STALL: re-evaluate each cycle and return to ISSUE when eligible. Commands are never reordered or dropped.
- Strobes: at most one of o_push/o_pop per cycle, each a one-cycle pulse. Back-to-back issue (one per cycle) is allowed.
- i_task_fifo_full is sampled in the same cycle the strobe is registered. A push already issued is not retracted.
- Pop pipeline: POP_LAT-deep shift register of {valid, tree_id}.
  - When the last stage is valid, i_pop_data and its tree_id are written into the response FIFO the same cycle.
  - The credit rule guarantees this write never hits a full FIFO.
- Response FIFO: first-word fall-through; o_rsp_valid = !rsp_empty; pops when o_rsp_valid & i_rsp_ready.
  - A simultaneous write and read while full is not possible by the credit rule.
  - A simultaneous write and read while empty lets the data pass with one cycle of latency from capture.
- Counters: inflight_pops and rsp_count are width $clog2(RSP_DEPTH)+1 and never wrap.
  - Same-cycle increment and decrement leave the value unchanged.
- Overall latency: command accepted -> strobe no earlier than 2 cycles; strobe -> o_rsp_valid = POP_LAT+1 cycles.

Optional Feature:
- Macro: PIFO_LANE_SEQ_STATS_EN.
- When defined, adds three 32-bit saturating counters, cleared by i_rst:
  - o_stat_push_cnt: increments on each o_push.
  - o_stat_pop_cnt: increments on each o_pop.
  - o_stat_stall_cnt: increments each cycle the FSM is in STALL.
- When undefined, these ports and counters are absent, and behaviour is otherwise identical.

Test Plan:
- Reset, then 8 push commands with tree_id=3 and data 0x3000..0x3007, i_task_fifo_full=0 -> 8 consecutive o_push pulses with o_push_data 0x3000..0x3007, o_tree_id=3, o_busy falls after the last pulse.
- 4 pops with POP_LAT=2, PIFO model returning 0x3000..0x3003, i_rsp_ready=1 -> o_rsp_data 0x3000..0x3003 in order, each POP_LAT+1 cycles after its o_pop, o_rsp_tree_id=3.
- i_rsp_ready=0 with 6 pops queued and RSP_DEPTH=4 -> exactly 4 o_pop pulses, then STALL. Raising i_rsp_ready releases the remaining 2 pops, and all 6 responses arrive intact.
- i_task_fifo_full=1 for 10 cycles with a push at the FIFO head -> no o_push for those 10 cycles. The push issues on the first cycle the flag drops, and a queued pop behind it does not bypass it.
- Fill the command FIFO (4 entries) while blocked -> o_cmd_ready=0, and a 5th i_cmd_valid is not accepted. When one command dequeues, o_cmd_ready=1 next cycle.
- Assert i_rst with 2 pops in flight -> outputs return to reset values the next cycle, late i_pop_data is ignored, and o_rsp_valid stays 0.
